// File: rtl/i2c_controller.sv
// Single-controller I2C initiator: one byte write or one byte read (register pointer + repeated START).
// Bus outputs are registered, so SCL/SDA follow the internal quarter phase by one clk_i cycle.
module i2c_controller #(
  parameter int CLK_DIV = 62
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       rw_i,
  input  logic [6:0] address_i,
  input  logic [7:0] register_id_i,
  input  logic [7:0] write_value_i,
  output logic [7:0] read_value_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       nack_o,
  inout  wire        scl_io,
  inout  wire        sda_io
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_START   = 4'd1;
  localparam logic [3:0] S_ADDR    = 4'd2;
  localparam logic [3:0] S_ACK_A   = 4'd3;
  localparam logic [3:0] S_REG     = 4'd4;
  localparam logic [3:0] S_ACK_R   = 4'd5;
  localparam logic [3:0] S_WDATA   = 4'd6;
  localparam logic [3:0] S_ACK_W   = 4'd7;
  localparam logic [3:0] S_RSTART  = 4'd8;
  localparam logic [3:0] S_ADDR_RD = 4'd9;
  localparam logic [3:0] S_ACK_AR  = 4'd10;
  localparam logic [3:0] S_RDATA   = 4'd11;
  localparam logic [3:0] S_MNACK   = 4'd12;
  localparam logic [3:0] S_STOP    = 4'd13;
  localparam logic [3:0] S_DONE    = 4'd14;

  localparam logic [15:0] QMAX = 16'(CLK_DIV - 1);

  logic [3:0]  state_q, state_d;
  logic [15:0] qcnt_q, qcnt_d;
  logic [1:0]  quarter_q, quarter_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wval_q, wval_d;
  logic        nack_q, nack_d;
  logic [7:0]  rdval_q, rdval_d;
  logic        scl_oe_q, sda_oe_q;
  logic        scl_pull, sda_pull;

  logic tick, bit_end, sample, sda_in;

  assign tick    = (qcnt_q == QMAX);
  assign bit_end = tick && (quarter_q == 2'd3);
  assign sample  = (quarter_q == 2'd3) && (qcnt_q == 16'd0);
  assign sda_in  = sda_io;

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q + 16'd1;
    quarter_d = quarter_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    reg_d     = reg_q;
    wval_d    = wval_q;
    nack_d    = nack_q;
    rdval_d   = rdval_q;
    if (tick) begin
      qcnt_d    = 16'd0;
      quarter_d = quarter_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        qcnt_d    = 16'd0;
        quarter_d = 2'd0;
        if (start_i) begin
          rw_d    = rw_i;
          addr_d  = address_i;
          reg_d   = register_id_i;
          wval_d  = write_value_i;
          nack_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          shift_d  = {addr_q, 1'b0};
          bitcnt_d = 3'd0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR, S_REG, S_WDATA, S_ADDR_RD: begin
        if (bit_end) begin
          shift_d  = {shift_q[6:0], 1'b0};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            case (state_q)
              S_ADDR:  state_d = S_ACK_A;
              S_REG:   state_d = S_ACK_R;
              S_WDATA: state_d = S_ACK_W;
              default: state_d = S_ACK_AR;
            endcase
          end
        end
      end
      S_ACK_A, S_ACK_R, S_ACK_W, S_ACK_AR: begin
        // nack_q can only be set by this slot: earlier NACKs already went to STOP
        if (sample && sda_in) nack_d = 1'b1;
        if (bit_end) begin
          bitcnt_d = 3'd0;
          if (nack_q || state_q == S_ACK_W) begin
            state_d = S_STOP;
          end else begin
            case (state_q)
              S_ACK_A: begin
                shift_d = reg_q;
                state_d = S_REG;
              end
              S_ACK_R: begin
                shift_d = wval_q;
                state_d = rw_q ? S_RSTART : S_WDATA;
              end
              default: state_d = S_RDATA;
            endcase
          end
        end
      end
      S_RSTART: begin
        if (bit_end) begin
          shift_d  = {addr_q, 1'b1};
          bitcnt_d = 3'd0;
          state_d  = S_ADDR_RD;
        end
      end
      S_RDATA: begin
        if (sample) rx_d = {rx_q[6:0], sda_in};
        if (bit_end) begin
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_MNACK;
        end
      end
      S_MNACK: begin
        // Only a fully acknowledged read reaches here, so the result is committed now
        if (bit_end) begin
          rdval_d = rx_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) state_d = S_DONE;
      end
      S_DONE: begin
        qcnt_d    = 16'd0;
        quarter_d = 2'd0;
        state_d   = S_IDLE;
      end
      default: begin
        qcnt_d    = 16'd0;
        quarter_d = 2'd0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_comb begin
    scl_pull = 1'b0;
    sda_pull = 1'b0;
    case (state_q)
      S_START: sda_pull = quarter_q[1];
      S_ADDR, S_REG, S_WDATA, S_ADDR_RD: begin
        scl_pull = ~quarter_q[1];
        sda_pull = ~shift_q[7];
      end
      S_ACK_A, S_ACK_R, S_ACK_W, S_ACK_AR, S_RDATA, S_MNACK: scl_pull = ~quarter_q[1];
      S_RSTART: begin
        scl_pull = (quarter_q == 2'd0);
        sda_pull = (quarter_q == 2'd3);
      end
      S_STOP: begin
        scl_pull = (quarter_q == 2'd0);
        sda_pull = ~quarter_q[1];
      end
      default: begin
        scl_pull = 1'b0;
        sda_pull = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      qcnt_q    <= 16'd0;
      quarter_q <= 2'd0;
      bitcnt_q  <= 3'd0;
      shift_q   <= 8'h00;
      rx_q      <= 8'h00;
      rw_q      <= 1'b0;
      addr_q    <= 7'h00;
      reg_q     <= 8'h00;
      wval_q    <= 8'h00;
      nack_q    <= 1'b0;
      rdval_q   <= 8'h00;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      quarter_q <= quarter_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      reg_q     <= reg_d;
      wval_q    <= wval_d;
      nack_q    <= nack_d;
      rdval_q   <= rdval_d;
      scl_oe_q  <= scl_pull;
      sda_oe_q  <= sda_pull;
    end
  end

  assign scl_io       = scl_oe_q ? 1'b0 : 1'bz;
  assign sda_io       = sda_oe_q ? 1'b0 : 1'bz;
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o       = (state_q == S_DONE);
  assign nack_o       = nack_q;
  assign read_value_o = rdval_q;

endmodule

// File: tb/tb_i2c_controller.sv
// Directed bench for i2c_controller with a behavioural PCA9685-style target (auto-increment pointer).
module tb_i2c_controller;
  localparam int CLK_DIV = 4;
  localparam int BT      = 4 * CLK_DIV;
  localparam logic [6:0] TGT_ADDR = 7'h40;

  logic       clk = 1'b0;
  logic       rst_i, start_i, rw_i;
  logic [6:0] address_i;
  logic [7:0] register_id_i, write_value_i, read_value_o;
  logic       busy_o, done_o, nack_o;
  wire        scl, sda;

  pullup (scl);
  pullup (sda);

  always #5 clk = ~clk;

  i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .rw_i(rw_i),
    .address_i(address_i), .register_id_i(register_id_i), .write_value_i(write_value_i),
    .read_value_o(read_value_o), .busy_o(busy_o), .done_o(done_o), .nack_o(nack_o),
    .scl_io(scl), .sda_io(sda)
  );

  int checks = 0;
  int failures = 0;

  // Target model, oversampling the bus on the falling clk edge
  logic       tgt_drv = 1'b0;
  logic       ps = 1'b1, pd = 1'b1, cs, cd;
  logic       active = 1'b0, tx_dir = 1'b0, mack = 1'b0, rd = 1'b0;
  logic [7:0] sh = 8'h00, txb = 8'h00, ptr = 8'h00;
  logic [7:0] regs [256];
  logic [7:0] rx_log [$];
  int         bitn = 0, bidx = 0, start_n = 0, stop_n = 0;

  assign sda = tgt_drv ? 1'b0 : 1'bz;

  initial forever begin
    @(negedge clk);
    cs = scl;
    cd = sda;
    if (ps && cs && pd && !cd) begin
      start_n++; active = 1'b1; tx_dir = 1'b0; bitn = 0; bidx = 0; tgt_drv = 1'b0;
    end else if (ps && cs && !pd && cd) begin
      stop_n++; active = 1'b0; tgt_drv = 1'b0;
    end else if (active && !ps && cs) begin
      if (bitn < 8) sh = {sh[6:0], cd};
      else mack = cd;
      bitn++;
    end else if (active && ps && !cs) begin
      if (bitn == 8) begin
        if (!tx_dir) begin
          rx_log.push_back(sh);
          if (bidx == 0) begin
            if (sh[7:1] == TGT_ADDR) begin tgt_drv = 1'b1; rd = sh[0]; end
            else begin active = 1'b0; tgt_drv = 1'b0; end
          end else if (bidx == 1) begin
            ptr = sh; tgt_drv = 1'b1;
          end else begin
            regs[ptr] = sh; ptr = ptr + 8'd1; tgt_drv = 1'b1;
          end
        end else begin
          tgt_drv = 1'b0;
        end
      end else if (bitn == 9) begin
        bitn = 0;
        tgt_drv = 1'b0;
        if (tx_dir && mack) begin
          active = 1'b0;
        end else begin
          if (bidx == 0 && rd) tx_dir = 1'b1;
          bidx++;
          if (tx_dir) begin txb = regs[ptr]; ptr = ptr + 8'd1; tgt_drv = !txb[7]; end
        end
      end else if (tx_dir && bitn >= 1 && bitn <= 7) begin
        tgt_drv = !txb[7-bitn];
      end
    end
    ps = cs;
    pd = cd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one command and watches it to completion (bounded); noise re-pulses start_i with other values
  task automatic run_cmd(input logic rw, input logic [6:0] a, input logic [7:0] r, input logic [7:0] w,
                         input logic noise, output int lat, output int busy_n, output int done_n,
                         output int extra);
    lat = -1; busy_n = 0; done_n = 0; extra = 0;
    @(negedge clk);
    rw_i = rw; address_i = a; register_id_i = r; write_value_i = w; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int n = 1; n < 4000; n++) begin
      if (lat < 0 && sda === 1'b0) lat = n - 1;
      if (busy_o) busy_n++;
      if (done_o) begin done_n++; break; end
      start_i = noise && (n % 50 == 0);
      if (noise) begin address_i = 7'h41; write_value_i = 8'hFF; end
      @(negedge clk);
    end
    start_i = noise;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (busy_o || done_o) extra++;
    end
  endtask

  int lat, bn, dn, ex, s0, p0;

  initial begin
    rst_i = 1'b1; start_i = 1'b0; rw_i = 1'b0; address_i = 7'h00;
    register_id_i = 8'h00; write_value_i = 8'h00;
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    regs[8'hFE] = 8'h1E;
    repeat (3) @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_nack", nack_o, 0);
    chk("rst_rdval", read_value_o, 8'h00);
    rst_i = 1'b0;
    @(negedge clk);

    // Write 0xA5 to register 0x06 at 0x40
    rx_log.delete(); s0 = start_n; p0 = stop_n;
    run_cmd(1'b0, 7'h40, 8'h06, 8'hA5, 1'b0, lat, bn, dn, ex);
    chk("wr_latency", lat, 2 * CLK_DIV + 1);
    chk("wr_busy_cycles", bn, 29 * BT);
    chk("wr_done_pulses", dn, 1);
    chk("wr_after_idle", ex, 0);
    chk("wr_nack", nack_o, 0);
    chk("wr_nbytes", rx_log.size(), 3);
    chk("wr_byte0", rx_log[0], 8'h80);
    chk("wr_byte1", rx_log[1], 8'h06);
    chk("wr_byte2", rx_log[2], 8'hA5);
    chk("wr_reg6", regs[8'h06], 8'hA5);
    chk("wr_starts", start_n - s0, 1);
    chk("wr_stops", stop_n - p0, 1);

    // Read register 0xFE (target holds 0x1E)
    rx_log.delete(); s0 = start_n; p0 = stop_n;
    run_cmd(1'b1, 7'h40, 8'hFE, 8'h00, 1'b0, lat, bn, dn, ex);
    chk("rd_busy_cycles", bn, 39 * BT);
    chk("rd_done_pulses", dn, 1);
    chk("rd_nack", nack_o, 0);
    chk("rd_value", read_value_o, 8'h1E);
    chk("rd_nbytes", rx_log.size(), 3);
    chk("rd_byte0", rx_log[0], 8'h80);
    chk("rd_byte1", rx_log[1], 8'hFE);
    chk("rd_byte2", rx_log[2], 8'h81);
    chk("rd_starts", start_n - s0, 2);
    chk("rd_master_nack", mack, 1);
    chk("rd_stops", stop_n - p0, 1);

    // Absent target 0x41: STOP right after the address ACK slot
    rx_log.delete(); p0 = stop_n;
    run_cmd(1'b1, 7'h41, 8'h00, 8'h00, 1'b0, lat, bn, dn, ex);
    chk("na_busy_cycles", bn, 11 * BT);
    chk("na_done_pulses", dn, 1);
    chk("na_nack", nack_o, 1);
    chk("na_rdval_held", read_value_o, 8'h1E);
    chk("na_nbytes", rx_log.size(), 1);
    chk("na_byte0", rx_log[0], 8'h82);
    chk("na_stops", stop_n - p0, 1);

    // start_i re-pulsed mid-transaction and in the DONE cycle
    rx_log.delete();
    run_cmd(1'b0, 7'h40, 8'h07, 8'h3C, 1'b1, lat, bn, dn, ex);
    chk("ns_busy_cycles", bn, 29 * BT);
    chk("ns_done_pulses", dn, 1);
    chk("ns_no_second", ex, 0);
    chk("ns_nack_cleared", nack_o, 0);
    chk("ns_byte0", rx_log[0], 8'h80);
    chk("ns_reg7", regs[8'h07], 8'h3C);
    chk("ns_reg_ff_untouched", regs[8'hFF], 8'h00);

    // Reset during RDATA bit 3 (data 0x1E keeps SDA released by the target there)
    @(negedge clk);
    rw_i = 1'b1; address_i = 7'h40; register_id_i = 8'hFE; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (519) @(negedge clk);
    chk("ab_busy_before", busy_o, 1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("ab_scl", scl, 1);
    chk("ab_sda", sda, 1);
    chk("ab_busy", busy_o, 0);
    chk("ab_done", done_o, 0);
    chk("ab_rdval", read_value_o, 8'h00);
    repeat (5) @(negedge clk);

    // MODE1 write with AI, then read back
    run_cmd(1'b0, 7'h40, 8'h00, 8'h20, 1'b0, lat, bn, dn, ex);
    chk("lb_wr_done", dn, 1);
    chk("lb_wr_nack", nack_o, 0);
    chk("lb_mode1", regs[8'h00], 8'h20);
    run_cmd(1'b1, 7'h40, 8'h00, 8'h00, 1'b0, lat, bn, dn, ex);
    chk("lb_rd_latency", lat, 2 * CLK_DIV + 1);
    chk("lb_rd_busy", bn, 39 * BT);
    chk("lb_rd_done", dn, 1);
    chk("lb_rd_nack", nack_o, 0);
    chk("lb_rd_value", read_value_o, 8'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
